// File: rtl/dms_pkg.sv
// Shared types and constants for the dms PLL blocks.
// EEnet nodes are carried as IEEE-754 double bit patterns (V, I, R) so the
// node stays a plain synthesizable vector while still converting losslessly
// to real values with $bitstoreal in analogue-aware models.
package dms_pkg;

  typedef enum logic [1:0] {
    PFD_IDLE,
    PFD_UP,
    PFD_DN,
    PFD_BOTH
  } pfd_state_t;

  // Default charge-pump current magnitude in amperes.
  localparam real ICP_DEFAULT = 50e-6;

  typedef struct packed {
    logic [63:0] V;
    logic [63:0] I;
    logic [63:0] R;
  } eenet_t;

  // The bit pattern of +0.0 is all zeros, so the zero-current node is all zeros.
  localparam eenet_t EE_ZERO_I = '{V: 64'd0, I: 64'd0, R: 64'd0};

endpackage

// File: rtl/dms_edge_sync.sv
// Two-flop synchroniser plus a history flop for one asynchronous input.
// rise is high for exactly one clk cycle per synchronised rising edge.
module dms_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise
);

  logic s1;
  logic s2;
  logic s3;

  // Metastability chain followed by the previous-value flop used for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= async_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

endmodule

// File: rtl/dms_pfd_cp.sv
// Sampled phase-frequency detector with charge pump driving loop-filter node P.
// Reports signed phase error in clk cycles (+ve = ref leads) with a one-cycle strobe.
// Optional lock detector enabled by defining DMS_PFD_LOCKDET_EN; otherwise lock is 0.
module dms_pfd_cp
  import dms_pkg::*;
#(
  parameter real ICP       = ICP_DEFAULT,
  parameter int  MIN_PULSE = 2,
  parameter int  CNT_W     = 8,
  parameter int  LOCK_TOL  = 2,
  parameter int  LOCK_CNT  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ref_in,
  input  logic               fb_in,
  output logic               up,
  output logic               dn,
  output logic signed [CNT_W:0] err,
  output logic               err_vld,
  output logic               lock,
  output eenet_t             P
);

  localparam int HOLD_W = (MIN_PULSE > 1) ? $clog2(MIN_PULSE) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MIN_PULSE - 1);

  // Negative current is the positive pattern with the sign bit flipped.
  localparam logic [63:0] ICP_BITS = $realtobits(ICP);
  localparam eenet_t EE_POS_I = '{V: 64'd0, I: ICP_BITS, R: 64'd0};
  localparam eenet_t EE_NEG_I = '{V: 64'd0, I: {~ICP_BITS[63], ICP_BITS[62:0]}, R: 64'd0};

  logic ref_rise;
  logic fb_rise;

  pfd_state_t state;
  pfd_state_t state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [CNT_W-1:0]  cnt_inc;
  logic [HOLD_W-1:0] hold;
  logic [HOLD_W-1:0] hold_nxt;
  logic signed [CNT_W:0] err_nxt;
  logic err_vld_nxt;

  dms_edge_sync u_ref_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (ref_in),
    .rise     (ref_rise)
  );

  dms_edge_sync u_fb_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (fb_in),
    .rise     (fb_rise)
  );

  // The error value includes the cycle in which the closing edge lands.
  assign cnt_inc = (&cnt) ? cnt : cnt + 1'b1;

  // FSM and measurement state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= PFD_IDLE;
      cnt     <= '0;
      hold    <= '0;
      err     <= '0;
      err_vld <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      hold    <= hold_nxt;
      err     <= err_nxt;
      err_vld <= err_vld_nxt;
    end
  end

  // Next-state logic: edges in BOTH are dropped, same-side repeat edges are ignored.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    hold_nxt    = hold;
    err_nxt     = err;
    err_vld_nxt = 1'b0;
    case (state)
      PFD_IDLE: begin
        if (ref_rise && fb_rise) begin
          state_nxt   = PFD_BOTH;
          hold_nxt    = '0;
          err_nxt     = '0;
          err_vld_nxt = 1'b1;
        end else if (ref_rise) begin
          state_nxt = PFD_UP;
          cnt_nxt   = '0;
        end else if (fb_rise) begin
          state_nxt = PFD_DN;
          cnt_nxt   = '0;
        end
      end
      PFD_UP: begin
        if (fb_rise) begin
          state_nxt   = PFD_BOTH;
          hold_nxt    = '0;
          err_nxt     = $signed({1'b0, cnt_inc});
          err_vld_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      PFD_DN: begin
        if (ref_rise) begin
          state_nxt   = PFD_BOTH;
          hold_nxt    = '0;
          err_nxt     = -$signed({1'b0, cnt_inc});
          err_vld_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      PFD_BOTH: begin
        if (hold == HOLD_LAST) begin
          state_nxt = PFD_IDLE;
        end else begin
          hold_nxt = hold + 1'b1;
        end
      end
      default: begin
        state_nxt = PFD_IDLE;
      end
    endcase
  end

  // Registered pump controls, one cycle behind the FSM state.
  always_ff @(posedge clk) begin
    if (rst) begin
      up <= 1'b0;
      dn <= 1'b0;
    end else begin
      up <= (state == PFD_UP) || (state == PFD_BOTH);
      dn <= (state == PFD_DN) || (state == PFD_BOTH);
    end
  end

  // Charge-pump current onto P; overlapping up/dn cancel to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      P <= EE_ZERO_I;
    end else begin
      case ({up, dn})
        2'b10:   P <= EE_POS_I;
        2'b01:   P <= EE_NEG_I;
        default: P <= EE_ZERO_I;
      endcase
    end
  end

`ifdef DMS_PFD_LOCKDET_EN
  localparam int LC_W = $clog2(LOCK_CNT + 1);

  logic [LC_W-1:0]  lock_cnt;
  logic [CNT_W:0]   err_mag;

  assign err_mag = err[CNT_W] ? -err : err;

  // Count consecutive in-tolerance comparisons; any out-of-tolerance one restarts.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_cnt <= '0;
    end else if (err_vld) begin
      if (err_mag <= (CNT_W+1)'(LOCK_TOL)) begin
        if (lock_cnt != LC_W'(LOCK_CNT)) begin
          lock_cnt <= lock_cnt + 1'b1;
        end
      end else begin
        lock_cnt <= '0;
      end
    end
  end

  assign lock = (lock_cnt == LC_W'(LOCK_CNT));
`else
  logic lock_cfg_unused;

  assign lock_cfg_unused = (LOCK_TOL + LOCK_CNT) != 0;
  assign lock = 1'b0;
`endif

endmodule
